// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; a bounded starvation counter forces a fetch grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic        dm_byte,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_dm, grant_if;
  logic             ack_seen;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_dm  = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (starve_cnt < LIMIT || !if_req)) begin
          grant_dm  = 1'b1;
          state_nxt = BUSY_DM;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: if (mem_ack) state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // An ack only counts while a transaction is outstanding.
  assign ack_seen = mem_ack && (state == BUSY_IF || state == BUSY_DM);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_byte   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_byte  <= dm_byte;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_if) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_byte   <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end
      if (ack_seen) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_byte  <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        if (state == BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end else begin
          dm_valid <= 1'b1;
          // Stores complete with a pulse but leave the last load value in place.
          if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data priority, starvation, reset
// abort, back-to-back loads and spurious acks, all with hand-computed values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we, dm_byte;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_dm;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_first, t_second;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (mem_req) break;
      step();
    end
    check(tag, mem_req, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_req",  mem_req,  1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valids",   {if_valid, dm_valid, mem_we, mem_byte}, 4'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);

    // Fetch only, granted on the first edge after reset release, ack after 2 cycles.
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0040;
    step();
    check("f_req1",   mem_req,  1'b1);
    check("f_addr",   mem_addr, 32'h40);
    check("f_we",     mem_we,   1'b0);
    check("f_stall",  stall_if, 1'b1);
    step();
    check("f_req2", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h2408_0005;
    step();
    mem_ack = 1'b0;
    check("f_req_drop", mem_req,  1'b0);
    check("f_valid",    if_valid, 1'b1);
    check("f_rdata",    if_rdata, 32'h2408_0005);
    check("f_nostall",  stall_if, 1'b0);
    if_req = 1'b0;
    step();
    check("f_valid_pulse", if_valid, 1'b0);
    check("f_rdata_hold",  if_rdata, 32'h2408_0005);

    // Simultaneous store and fetch: data first, dm_rdata untouched by the store.
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    step();
    check("s_addr",   mem_addr,  32'h100);
    check("s_we",     mem_we,    1'b1);
    check("s_wdata",  mem_wdata, 32'hDEAD_BEEF);
    check("s_stalls", {stall_if, stall_dm}, 2'b11);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    check("s_dm_valid", {dm_valid, if_valid}, 2'b10);
    check("s_dm_rdata", dm_rdata, 32'h0);
    check("s_stall_if", stall_if, 1'b1);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    check("s_stall_if_idle", stall_if, 1'b1);
    wait_req("s_fetch_req");
    check("s_fetch_addr", mem_addr, 32'h80);
    check("s_fetch_we",   mem_we,   1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h8C09_0000;
    step();
    mem_ack = 1'b0;
    check("s_if_valid", if_valid, 1'b1);
    check("s_if_rdata", if_rdata, 32'h8C09_0000);
    if_req = 1'b0;
    step();

    // Starvation: four data grants while fetch waits, then the fetch.
    if_req = 1'b1; if_addr = 32'hC0;
    dm_req = 1'b1; dm_addr = 32'h200;
    for (int g = 0; g < 5; g++) begin
      wait_req("st_req");
      check("st_grant_addr", mem_addr, (g < 4) ? 32'h200 : 32'hC0);
      mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + g;
      step();
      mem_ack = 1'b0;
      check("st_valids", {dm_valid, if_valid}, (g < 4) ? 2'b10 : 2'b01);
      if (g == 4) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      step();
    end
    check("st_dm_rdata", dm_rdata, 32'hA000_0003);
    check("st_if_rdata", if_rdata, 32'hA000_0004);

    // Counter cleared by the fetch grant, so data wins again.
    if_req = 1'b1; if_addr = 32'hC4;
    dm_req = 1'b1; dm_addr = 32'h208;
    wait_req("cl_req1");
    check("cl_data_first", mem_addr, 32'h208);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    check("cl_dm_valid", dm_valid, 1'b1);
    dm_req = 1'b0;
    step();
    wait_req("cl_req2");
    check("cl_fetch_addr", mem_addr, 32'hC4);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    mem_ack = 1'b0;
    check("cl_if_valid", if_valid, 1'b1);
    if_req = 1'b0;
    step();

    // Back-to-back loads: byte at 0x203 then word at 0x204.
    dm_req = 1'b1; dm_byte = 1'b1; dm_addr = 32'h203;
    step();
    check("bb_byte1", mem_byte, 1'b1);
    check("bb_addr1", mem_addr, 32'h203);
    mem_ack = 1'b1; mem_rdata = 32'h0000_00AB;
    step();
    mem_ack = 1'b0;
    check("bb_valid1", dm_valid, 1'b1);
    check("bb_rdata1", dm_rdata, 32'h0000_00AB);
    t_first = cyc;
    dm_byte = 1'b0; dm_addr = 32'h204;
    step();
    check("bb_gap_idle", dm_valid, 1'b0);
    step();
    check("bb_byte2", mem_byte, 1'b0);
    check("bb_addr2", mem_addr, 32'h204);
    check("bb_gap_busy", dm_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    check("bb_valid2", dm_valid, 1'b1);
    t_second = cyc;
    check("bb_spacing", t_second - t_first, 32'd3);
    check("bb_rdata2", dm_rdata, 32'hCAFE_F00D);
    dm_req = 1'b0;
    step();

    // Spurious ack in IDLE.
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    check("sp_valids",   {if_valid, dm_valid, mem_req}, 3'b000);
    check("sp_dm_rdata", dm_rdata, 32'hCAFE_F00D);
    check("sp_if_rdata", if_rdata, 32'h2222_2222);
    step();
    check("sp_still_idle", mem_req, 1'b0);

    // Reset during BUSY_DM, then a late ack.
    dm_req = 1'b1; dm_addr = 32'h300;
    step();
    check("rm_busy", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rm_async_req",  mem_req,  1'b0);
    check("rm_async_addr", mem_addr, 32'h0);
    step();
    rst_n = 1'b1; dm_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 1'b0;
    check("rm_no_valid", {dm_valid, if_valid, mem_req}, 3'b000);
    check("rm_dm_rdata", dm_rdata, 32'h0);
    step();
    check("rm_idle", {dm_valid, mem_req}, 2'b00);
    // Still in IDLE: a fresh fetch is granted on the very next edge.
    if_req = 1'b1; if_addr = 32'h44;
    step();
    check("rm_regrant", {mem_req, mem_addr[7:0]}, {1'b1, 8'h44});
    mem_ack = 1'b1; mem_rdata = 32'h7;
    step();
    mem_ack = 1'b0; if_req = 1'b0;
    check("rm_if_valid", if_valid, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
